// File: rtl/score_bcd_counter.sv
// score_bcd_counter: saturating game-score accumulator with a one-bit-per-clock
// shift-add-3 binary-to-BCD converter. The bcd/lz_mask outputs only update when
// a full conversion completes, so the seven-segment readout never sees partial
// values.
module score_bcd_counter #(
  parameter int SCORE_W   = 20,
  parameter int PTS_W     = 8,
  parameter int DIGITS    = 6,
  parameter int MAX_SCORE = 999999
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clear,
  input  logic                  add_valid,
  input  logic [PTS_W-1:0]      add_points,
  output logic [SCORE_W-1:0]    score,
  output logic                  saturated,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     lz_mask,
  output logic                  bcd_update
);

  localparam int CNT_W = $clog2(SCORE_W + 1);
  localparam logic [SCORE_W:0] MAX_EXT = (SCORE_W+1)'(MAX_SCORE);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                r_state;
  logic [SCORE_W-1:0]    r_score;
  logic                  r_sat;
  logic                  r_dirty;
  logic [SCORE_W-1:0]    r_bin;
  logic [4*DIGITS-1:0]   r_work;
  logic [CNT_W-1:0]      r_cnt;
  logic [4*DIGITS-1:0]   r_bcd;
  logic [DIGITS-1:0]     r_lz;
  logic                  r_upd;

  logic [SCORE_W:0]      w_sum;
  logic                  w_over;
  logic                  w_set_dirty;
  logic [4*DIGITS-1:0]   w_adj;
  logic [DIGITS-1:0]     w_nz;
  logic [DIGITS-1:0]     w_lz;

  // One extra bit on the sum so an overflow past 2^SCORE_W still compares high.
  assign w_sum       = {1'b0, r_score} + {{(SCORE_W+1-PTS_W){1'b0}}, add_points};
  assign w_over      = (w_sum > MAX_EXT);
  assign w_set_dirty = clear | add_valid;

  // Per-digit add-3 correction and nonzero flags for leading-zero blanking.
  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    assign w_adj[4*d +: 4] = (r_work[4*d +: 4] >= 4'd5) ? r_work[4*d +: 4] + 4'd3
                                                         : r_work[4*d +: 4];
    assign w_nz[d] = |r_work[4*d +: 4];
    if (d == 0) begin : g_lz0
      assign w_lz[d] = 1'b1;
    end else begin : g_lzn
      assign w_lz[d] = |(w_nz >> d);
    end
  end

  // Score accumulation; clear beats add, sums past the ceiling clamp and stick.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_score <= '0;
      r_sat   <= 1'b0;
    end else if (clear) begin
      r_score <= '0;
      r_sat   <= 1'b0;
    end else if (add_valid) begin
      if (w_over) begin
        r_score <= MAX_EXT[SCORE_W-1:0];
        r_sat   <= 1'b1;
      end else begin
        r_score <= w_sum[SCORE_W-1:0];
      end
    end
  end

  // Conversion FSM: snapshot, SCORE_W shift-add-3 steps, then publish once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_dirty <= 1'b0;
      r_bin   <= '0;
      r_work  <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
      r_lz    <= {{(DIGITS-1){1'b0}}, 1'b1};
      r_upd   <= 1'b0;
    end else begin
      r_upd <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_dirty) begin
            r_bin   <= r_score;
            r_work  <= '0;
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          // Top digit never carries out because MAX_SCORE < 10^DIGITS.
          r_work <= (4*DIGITS)'({w_adj, r_bin[SCORE_W-1]});
          r_bin  <= {r_bin[SCORE_W-2:0], 1'b0};
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(SCORE_W-1)) r_state <= DONE;
        end
        DONE: begin
          r_bcd   <= r_work;
          r_lz    <= w_lz;
          r_upd   <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      // A new add/clear on the snapshot edge keeps dirty set for the next pass.
      if (w_set_dirty)                      r_dirty <= 1'b1;
      else if (r_state == IDLE && r_dirty)  r_dirty <= 1'b0;
    end
  end

  assign score      = r_score;
  assign saturated  = r_sat;
  assign busy       = (r_state != IDLE);
  assign bcd        = r_bcd;
  assign lz_mask    = r_lz;
  assign bcd_update = r_upd;

endmodule
